// File: rtl/vga_pkg.sv
// Shared constants and state type for the VGA LCD pixel pipeline.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'b00,
    ST_RUN    = 2'b01,
    ST_STARVE = 2'b10
  } vga_state_t;

  localparam int unsigned VGA_DEPTH_LOG2 = 4;
  localparam int unsigned VGA_PIX_DIV    = 4;

endpackage

// File: rtl/vga_pix_phase.sv
// Modulo-PIX_DIV phase counter with first/last strobes for divided-clock enables.
import vga_pkg::*;

module vga_pix_phase #(
  parameter int unsigned PIX_DIV = VGA_PIX_DIV,
  parameter int unsigned PW      = $clog2(PIX_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] phase_o,
  output logic          first_o,
  output logic          last_o
);

  localparam logic [PW-1:0] LAST = PW'(PIX_DIV - 1);

  always_ff @(posedge clk) begin
    if (rst)
      phase_o <= '0;
    else if (last_o)
      phase_o <= '0;
    else
      phase_o <= phase_o + 1'b1;
  end

  always_comb begin
    first_o = (phase_o == '0);
    last_o  = (phase_o == LAST);
  end

endmodule

// File: rtl/vga_pipe_sched.sv
// Pixel-pipeline flow scheduler: FIFO fill enable, paced FIFO reads / DAC enables,
// prime/run/starve control and sticky underrun/overflow status.
import vga_pkg::*;

module vga_pipe_sched #(
  parameter int unsigned DEPTH_LOG2   = VGA_DEPTH_LOG2,
  parameter int unsigned PIX_DIV      = VGA_PIX_DIV,
  parameter int unsigned PRIME_LEVEL  = 8,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       csr_stb_i,
  input  logic                       csr_ack_i,
  input  logic [DEPTH_LOG2:0]        fifo_nword,
  output logic                       enable_front,
  output logic                       fifo_rreq,
  output logic                       enable_back,
  input  logic                       underrun_clr,
  input  logic                       overflow_clr,
  output logic                       underrun,
  output logic                       overflow,
  output logic [1:0]                 state_o,
  output logic [$clog2(PIX_DIV)-1:0] phase_o
);

  localparam int unsigned NW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = $clog2(PIX_DIV);

  localparam logic [NW-1:0] AFULL_LVL = NW'(DEPTH - AFULL_MARGIN);
  localparam logic [NW-1:0] PRIME_LVL = NW'(PRIME_LEVEL);
  localparam logic [NW-1:0] FULL_LVL  = NW'(DEPTH);

  vga_state_t state_q, state_d;
  logic       first, last;
  logic       afull, empty, full, primed;
  logic       front_ok;
  logic       slot_run_q;
  logic       underrun_set, overflow_set;

  vga_pix_phase #(
    .PIX_DIV (PIX_DIV),
    .PW      (PW)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .phase_o (phase_o),
    .first_o (first),
    .last_o  (last)
  );

  always_comb begin
    afull    = (fifo_nword >= AFULL_LVL);
    empty    = (fifo_nword == '0);
    full     = (fifo_nword == FULL_LVL);
    primed   = (fifo_nword >= PRIME_LVL);
    // An open memory cycle is only gated by its ack, never by afull.
    front_ok = (csr_stb_i & csr_ack_i) | (~csr_stb_i & ~afull);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_PRIME;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    enable_front = 1'b0;
    fifo_rreq    = 1'b0;
    enable_back  = 1'b0;
    underrun_set = 1'b0;
    overflow_set = 1'b0;

    case (state_q)
      ST_PRIME, ST_STARVE: if (primed && last) state_d = ST_RUN;
      ST_RUN:              if (first && empty) state_d = ST_STARVE;
      default:             state_d = ST_PRIME;
    endcase

    if (!rst) begin
      enable_front = front_ok;
      fifo_rreq    = (state_q == ST_RUN) & first & ~empty;
      // The DAC slot belongs to the pixel whose phase 0 was spent in RUN,
      // so a starving pixel still gets its (repeated) enable.
      enable_back  = last & slot_run_q;
      underrun_set = (state_q == ST_RUN) & first & empty;
      overflow_set = front_ok & full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      slot_run_q <= 1'b0;
    else if (first)
      slot_run_q <= (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
      if (overflow_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_vga_pipe_sched.sv
// Self-checking bench for vga_pipe_sched against a cycle-count based reference model.
module tb_vga_pipe_sched;

  localparam int DLOG  = 4;
  localparam int PD    = 4;
  localparam int PL    = 8;
  localparam int AM    = 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, csr_stb_i, csr_ack_i, underrun_clr, overflow_clr;
  logic [4:0] fifo_nword;
  logic       enable_front, fifo_rreq, enable_back, underrun, overflow;
  logic [1:0] state_o;
  logic [1:0] phase_o;

  int n_chk = 0;
  int n_fail = 0;

  // Model: 0 PRIME, 1 RUN, 2 STARVE; phase derived from cycles since reset.
  int m_st, m_cyc, m_age;
  bit m_under, m_over;
  bit e_front, e_rreq, e_back;

  vga_pipe_sched #(
    .DEPTH_LOG2   (DLOG),
    .PIX_DIV      (PD),
    .PRIME_LEVEL  (PL),
    .AFULL_MARGIN (AM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_stb_i    (csr_stb_i),
    .csr_ack_i    (csr_ack_i),
    .fifo_nword   (fifo_nword),
    .enable_front (enable_front),
    .fifo_rreq    (fifo_rreq),
    .enable_back  (enable_back),
    .underrun_clr (underrun_clr),
    .overflow_clr (overflow_clr),
    .underrun     (underrun),
    .overflow     (overflow),
    .state_o      (state_o),
    .phase_o      (phase_o)
  );

  always #5 clk = ~clk;

  function automatic void model_outs();
    int  ph;
    bit  afull;
    ph    = m_cyc % PD;
    afull = int'(fifo_nword) >= DEPTH - AM;
    if (rst) begin
      e_front = 0; e_rreq = 0; e_back = 0;
    end else begin
      e_front = (csr_stb_i && csr_ack_i) || (!csr_stb_i && !afull);
      e_rreq  = (m_st == 1) && (ph == 0) && (fifo_nword != 0);
      e_back  = (ph == PD - 1) && ((m_st == 1) || (m_st == 2 && m_age < PD));
    end
  endfunction

  function automatic logic [5:0] m_regs();
    return {2'(m_st), 2'(m_cyc % PD), m_under, m_over};
  endfunction

  task automatic tick();
    int ph;
    model_outs();
    if (rst) begin
      m_st = 0; m_cyc = 0; m_under = 0; m_over = 0; m_age = 0;
    end else begin
      ph = m_cyc % PD;
      if (e_front && fifo_nword == DEPTH) m_over = 1;
      else if (overflow_clr)              m_over = 0;
      if (m_st == 1 && ph == 0 && fifo_nword == 0) m_under = 1;
      else if (underrun_clr)                        m_under = 0;
      case (m_st)
        1: if (ph == 0 && fifo_nword == 0) begin m_st = 2; m_age = 1; end
        default: begin
          if (fifo_nword >= PL && ph == PD - 1) m_st = 1;
          else if (m_st == 2) m_age++;
        end
      endcase
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; csr_stb_i = 0; csr_ack_i = 0; fifo_nword = 0;
    underrun_clr = 0; overflow_clr = 0;
    tick();
    tick();
    n_chk++;
    if ({state_o, phase_o, underrun, overflow} !== 6'b00_00_0_0) begin
      n_fail++;
      $display("FAIL reset_regs: got %b exp %b", {state_o, phase_o, underrun, overflow}, 6'b0);
    end
    n_chk++;
    if ({enable_front, fifo_rreq, enable_back} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_enables: got %b exp 000", {enable_front, fifo_rreq, enable_back});
    end
  endtask

  task automatic test_prime();
    int nw = 0;
    int first_run = -1;
    int first_rd = -1;
    rst = 0;
    for (int k = 0; k < 24; k++) begin
      fifo_nword = 5'(nw);
      #1;
      model_outs();
      n_chk++;
      if ({enable_front, fifo_rreq, enable_back} !== {e_front, e_rreq, e_back}) begin
        n_fail++;
        $display("FAIL prime_outs k=%0d: got %b exp %b", k,
                 {enable_front, fifo_rreq, enable_back}, {e_front, e_rreq, e_back});
      end
      if (fifo_rreq === 1'b1 && first_rd < 0) first_rd = k;
      tick();
      n_chk++;
      if ({state_o, phase_o, underrun, overflow} !== m_regs()) begin
        n_fail++;
        $display("FAIL prime_regs k=%0d: got %b exp %b", k,
                 {state_o, phase_o, underrun, overflow}, m_regs());
      end
      if (state_o === 2'b01 && first_run < 0) first_run = k + 1;
      if (e_front && nw < PL) nw++;
      if (e_rreq) nw--;
    end
    n_chk++;
    if (first_run !== 12 || first_rd !== 12) begin
      n_fail++;
      $display("FAIL prime_first_read: run at %0d read at %0d exp 12/12", first_run, first_rd);
    end
  endtask

  task automatic test_steady();
    int reads = 0;
    fifo_nword = 10;
    for (int k = 0; k < 16; k++) begin
      #1;
      model_outs();
      n_chk++;
      if ({enable_front, fifo_rreq, enable_back} !== {e_front, e_rreq, e_back}) begin
        n_fail++;
        $display("FAIL steady_outs k=%0d: got %b exp %b", k,
                 {enable_front, fifo_rreq, enable_back}, {e_front, e_rreq, e_back});
      end
      if (fifo_rreq === 1'b1) reads++;
      tick();
      n_chk++;
      if ({state_o, phase_o, underrun, overflow} !== m_regs()) begin
        n_fail++;
        $display("FAIL steady_regs k=%0d: got %b exp %b", k,
                 {state_o, phase_o, underrun, overflow}, m_regs());
      end
    end
    n_chk++;
    if (reads !== 4) begin
      n_fail++;
      $display("FAIL steady_read_count: got %0d exp 4", reads);
    end
  endtask

  task automatic test_front_enable();
    logic [6:0] tbl [4] = '{ {5'd14, 1'b0, 1'b0}, {5'd14, 1'b1, 1'b0},
                             {5'd14, 1'b1, 1'b1}, {5'd13, 1'b0, 1'b0} };
    logic       exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      {fifo_nword, csr_stb_i, csr_ack_i} = tbl[i];
      #1;
      n_chk++;
      if (enable_front !== exp[i]) begin
        n_fail++;
        $display("FAIL front_enable case %0d: got %b exp %b", i, enable_front, exp[i]);
      end
      tick();
    end
    csr_stb_i = 0; csr_ack_i = 0;
  endtask

  task automatic test_overflow();
    fifo_nword = 16; csr_stb_i = 1; csr_ack_i = 0;
    tick();
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_stalled_cycle: got %b exp 0", overflow);
    end
    csr_ack_i = 1;
    tick();
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b exp 1", overflow);
    end
    overflow_clr = 1;
    tick();
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_beats_clr: got %b exp 1", overflow);
    end
    fifo_nword = 10; csr_stb_i = 0; csr_ack_i = 0;
    tick();
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b exp 0", overflow);
    end
    overflow_clr = 0;
    n_chk++;
    if ({state_o, phase_o, underrun, overflow} !== m_regs()) begin
      n_fail++;
      $display("FAIL ovf_regs: got %b exp %b", {state_o, phase_o, underrun, overflow}, m_regs());
    end
  endtask

  task automatic test_underrun();
    fifo_nword = 10;
    for (int i = 0; i < 2 * PD && (m_cyc % PD) != 0; i++) tick();
    fifo_nword = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      model_outs();
      n_chk++;
      if ({enable_front, fifo_rreq, enable_back} !== {e_front, e_rreq, e_back}) begin
        n_fail++;
        $display("FAIL starve_outs k=%0d: got %b exp %b", k,
                 {enable_front, fifo_rreq, enable_back}, {e_front, e_rreq, e_back});
      end
      if ((k == 3 && enable_back !== 1'b1) || (k == 7 && enable_back !== 1'b0)
          || (k == 0 && fifo_rreq !== 1'b0)) begin
        n_fail++;
        $display("FAIL starve_slot k=%0d: got rreq %b back %b", k, fifo_rreq, enable_back);
      end
      n_chk++;
      tick();
      n_chk++;
      if ({state_o, phase_o, underrun, overflow} !== m_regs()) begin
        n_fail++;
        $display("FAIL starve_regs k=%0d: got %b exp %b", k,
                 {state_o, phase_o, underrun, overflow}, m_regs());
      end
      if (k == 0) begin
        n_chk++;
        if (state_o !== 2'b10 || underrun !== 1'b1) begin
          n_fail++;
          $display("FAIL starve_entry: got state %b underrun %b exp 10/1", state_o, underrun);
        end
      end
    end
    fifo_nword = 8;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++;
      if (state_o !== (k == 0 ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL refill k=%0d: got state %b exp %b", k, state_o, (k == 0 ? 2'b10 : 2'b01));
      end
    end
    underrun_clr = 1;
    tick();
    underrun_clr = 0;
    n_chk++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: got %b exp 0", underrun);
    end
  endtask

  task automatic test_reset_mid();
    fifo_nword = 16; csr_stb_i = 1; csr_ack_i = 1;
    tick();
    fifo_nword = 12; csr_stb_i = 0; csr_ack_i = 0;
    tick();
    rst = 1;
    #1;
    n_chk++;
    if ({enable_front, fifo_rreq, enable_back} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid_enables: got %b exp 000", {enable_front, fifo_rreq, enable_back});
    end
    tick();
    n_chk++;
    if ({state_o, phase_o, underrun, overflow, enable_front, fifo_rreq, enable_back} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_mid_regs: got %b exp 0",
               {state_o, phase_o, underrun, overflow, enable_front, fifo_rreq, enable_back});
    end
    rst = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 79) == 0);
      csr_stb_i    = $urandom_range(0, 1);
      csr_ack_i    = $urandom_range(0, 1);
      underrun_clr = ($urandom_range(0, 7) == 0);
      overflow_clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       fifo_nword = 5'($urandom_range(0, 1));
        1:       fifo_nword = 5'($urandom_range(13, 16));
        default: fifo_nword = 5'($urandom_range(0, 16));
      endcase
      #1;
      model_outs();
      n_chk++;
      if ({enable_front, fifo_rreq, enable_back} !== {e_front, e_rreq, e_back}) begin
        n_fail++;
        $display("FAIL random_outs k=%0d: got %b exp %b", k,
                 {enable_front, fifo_rreq, enable_back}, {e_front, e_rreq, e_back});
      end
      tick();
      n_chk++;
      if ({state_o, phase_o, underrun, overflow} !== m_regs()) begin
        n_fail++;
        $display("FAIL random_regs k=%0d: got %b exp %b", k,
                 {state_o, phase_o, underrun, overflow}, m_regs());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_steady();
    test_front_enable();
    test_overflow();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
